// File: rtl/approx_mul_char.sv
// approx_mul_char: on-board accuracy characterization engine for an external
// (approximate) W x W multiplier. It sweeps every operand pair (a major,
// b minor), reads back the product after LAT cycles, and compares it with
// the exact product. The result is an error count, a sum of absolute
// errors, and the largest error together with the first operands that
// produced it.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active high
//   start      begin a sweep (honoured only in IDLE or DONE)
//   a_out      operand a presented to the multiplier under test
//   b_out      operand b presented to the multiplier under test
//   prod_in    product returned by the multiplier under test
//   busy       sweep or drain in progress
//   done       results valid; sticky until the next start or rst
//   err_count  number of pairs with a nonzero error
//   err_sum    sum of |exact - prod_in|
//   max_err    largest |exact - prod_in|
//   max_a      operand a of the first pair reaching max_err
//   max_b      operand b of the first pair reaching max_err
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, waiting for start
// SWEEP | issuing one operand pair per cycle, comparing returned products
// DRAIN | all pairs issued, waiting for the last product to be compared
// DONE  | results valid and held, waiting for start

module approx_mul_char #(
  parameter int W   = 8,
  parameter int LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [W-1:0]     a_out,
  output logic [W-1:0]     b_out,
  input  logic [2*W-1:0]   prod_in,
  output logic             busy,
  output logic             done,
  output logic [2*W:0]     err_count,
  output logic [4*W-1:0]   err_sum,
  output logic [2*W-1:0]   max_err,
  output logic [W-1:0]     max_a,
  output logic [W-1:0]     max_b
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t state;

  // Valid flag for the pair currently presented on a_out/b_out.
  logic issue_v;

  // Compare-point view of the operands: the pair whose product is on
  // prod_in in this cycle.
  logic [W-1:0]   tap_a;
  logic [W-1:0]   tap_b;
  logic           tap_v;
  logic           pipe_busy;

  logic [2*W-1:0] exact;
  logic [2*W-1:0] err;

  // The operand registers themselves are the first stage of the alignment
  // delay line; LAT further stages follow them so that every product is
  // compared against the operands that produced it.
  generate
    if (LAT == 0) begin : g_nodly
      assign tap_a     = a_out;
      assign tap_b     = b_out;
      assign tap_v     = issue_v;
      assign pipe_busy = issue_v;
    end else begin : g_dly
      logic [W-1:0] dly_a [1:LAT];
      logic [W-1:0] dly_b [1:LAT];
      logic         dly_v [1:LAT];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 1; i <= LAT; i++) begin
            dly_a[i] <= '0;
            dly_b[i] <= '0;
            dly_v[i] <= 1'b0;
          end
        end else begin
          dly_a[1] <= a_out;
          dly_b[1] <= b_out;
          dly_v[1] <= issue_v;
          for (int i = 2; i <= LAT; i++) begin
            dly_a[i] <= dly_a[i-1];
            dly_b[i] <= dly_b[i-1];
            dly_v[i] <= dly_v[i-1];
          end
        end
      end

      assign tap_a = dly_a[LAT];
      assign tap_b = dly_b[LAT];
      assign tap_v = dly_v[LAT];

      // DRAIN may only finish once no pair is left anywhere in flight.
      always_comb begin
        pipe_busy = issue_v;
        for (int i = 1; i <= LAT; i++) begin
          pipe_busy = pipe_busy | dly_v[i];
        end
      end
    end
  endgenerate

  assign exact = (2*W)'(tap_a) * (2*W)'(tap_b);
  assign err   = (exact >= prod_in) ? (exact - prod_in) : (prod_in - exact);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_out     <= '0;
      b_out     <= '0;
      issue_v   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
      err_sum   <= '0;
      max_err   <= '0;
      max_a     <= '0;
      max_b     <= '0;
    end else begin
      // Accumulate the compare in flight; the start branch below overrides
      // this, but the pipeline is always empty in IDLE/DONE anyway.
      if (tap_v) begin
        if (err != '0) begin
          err_count <= err_count + (2*W+1)'(1);
          err_sum   <= err_sum + (4*W)'(err);
        end
        // Strictly greater: a tie keeps the earliest pair.
        if (err > max_err) begin
          max_err <= err;
          max_a   <= tap_a;
          max_b   <= tap_b;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= SWEEP;
            a_out     <= '0;
            b_out     <= '0;
            issue_v   <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            err_count <= '0;
            err_sum   <= '0;
            max_err   <= '0;
            max_a     <= '0;
            max_b     <= '0;
          end
        end

        SWEEP: begin
          // a_out/b_out keep the last pair (all ones) after the sweep.
          if ({a_out, b_out} == '1) begin
            issue_v <= 1'b0;
            state   <= DRAIN;
          end else begin
            {a_out, b_out} <= {a_out, b_out} + (2*W)'(1);
          end
        end

        DRAIN: begin
          if (!pipe_busy) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mul_char.sv
// Bench for approx_mul_char at W=4 (256 pairs per sweep). Two instances:
// one with LAT=0 driven by a combinational multiplier model with selectable
// faults, one with LAT=2 driven by a registered exact multiplier whose
// depth can be set to 2 (aligned) or 1 (misaligned).

module tb_approx_mul_char;

  localparam int W = 4;
  localparam int N = 1 << (2*W);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start2 = 1'b0;

  always #5 clk = ~clk;

  logic [W-1:0]   a0, b0, a2, b2, ma0, mb0, ma2, mb2;
  logic [2*W-1:0] p0, p2, me0, me2;
  logic           busy0, done0, busy2, done2;
  logic [2*W:0]   ec0, ec2;
  logic [4*W-1:0] es0, es2;

  int             mode = 0;
  logic           one_reg = 1'b0;
  logic [2*W-1:0] r1, r2;

  approx_mul_char #(.W(W), .LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .start(start0),
    .a_out(a0), .b_out(b0), .prod_in(p0),
    .busy(busy0), .done(done0),
    .err_count(ec0), .err_sum(es0), .max_err(me0),
    .max_a(ma0), .max_b(mb0)
  );

  approx_mul_char #(.W(W), .LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .start(start2),
    .a_out(a2), .b_out(b2), .prod_in(p2),
    .busy(busy2), .done(done2),
    .err_count(ec2), .err_sum(es2), .max_err(me2),
    .max_a(ma2), .max_b(mb2)
  );

  // Multiplier-under-test models.
  // mode 0: exact, 1: tied to zero, 2: bit0 forced 0, 3: +(a-b) when a>b
  function automatic logic [2*W-1:0] mut(input int m, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] e;
    e = (2*W)'(a) * (2*W)'(b);
    case (m)
      0:       return e;
      1:       return '0;
      2:       return {e[2*W-1:1], 1'b0};
      default: return (a > b) ? e + (2*W)'(a - b) : e;
    endcase
  endfunction

  assign p0 = mut(mode, a0, b0);

  always @(posedge clk) begin
    r1 <= (2*W)'(a2) * (2*W)'(b2);
    r2 <= r1;
  end
  assign p2 = one_reg ? r1 : r2;

  // Instance selection for the shared sweep task.
  logic           sel = 1'b0;
  logic           s_busy, s_done;
  logic [2*W:0]   s_ec;
  logic [4*W-1:0] s_es;
  logic [2*W-1:0] s_me;
  logic [W-1:0]   s_ma, s_mb, s_a, s_b;
  assign s_busy = sel ? busy2 : busy0;
  assign s_done = sel ? done2 : done0;
  assign s_ec   = sel ? ec2 : ec0;
  assign s_es   = sel ? es2 : es0;
  assign s_me   = sel ? me2 : me0;
  assign s_ma   = sel ? ma2 : ma0;
  assign s_mb   = sel ? mb2 : mb0;
  assign s_a    = sel ? a2 : a0;
  assign s_b    = sel ? b2 : b0;

  typedef struct {
    longint cnt;
    longint sum;
    longint maxe;
    longint ma;
    longint mb;
    longint cyc;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int m, input int lat);
    exp_t e;
    longint ex, p, d;
    e.cnt = 0; e.sum = 0; e.maxe = 0; e.ma = 0; e.mb = 0;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        ex = a * b;
        p  = longint'(mut(m, W'(a), W'(b)));
        d  = (ex >= p) ? ex - p : p - ex;
        if (d != 0) begin
          e.cnt++;
          e.sum += d;
        end
        if (d > e.maxe) begin
          e.maxe = d; e.ma = a; e.mb = b;
        end
      end
    end
    e.cyc = N + lat + 1;
    return e;
  endfunction

  int last_cyc;

  // Starts a sweep on the selected instance, optionally pulses start again
  // mid-sweep, waits (bounded) for done, and compares against the
  // scoreboard entry pushed at start.
  task automatic run_sweep(input bit use2, input int m, input int pulse_at, input bit use_sb);
    exp_t e;
    int   n;
    bit   got;
    @(negedge clk);
    sel  = use2;
    mode = m;
    if (use_sb) exp_q.push_back(model(use2 ? 0 : m, use2 ? 2 : 0));
    if (use2) start2 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start2 = 1'b0;
    check("start_busy", s_busy, 1);
    check("start_done_clr", s_done, 0);
    check("start_cnt_clr", s_ec, 0);
    check("start_max_clr", s_me, 0);
    check("start_a0", {s_a, s_b}, 0);
    n = 0;
    got = 0;
    while (n < N + 50 && !got) begin
      @(posedge clk);
      n++;
      #1;
      if (use2) start2 = (n == pulse_at); else start0 = (n == pulse_at);
      got = s_done;
    end
    start0 = 1'b0;
    start2 = 1'b0;
    last_cyc = n;
    if (!got) check("done_timeout", 0, 1);
    check("done_busy_low", s_busy, 0);
    if (use_sb) begin
      e = exp_q.pop_front();
      check("cycles", n, e.cyc);
      check("err_count", s_ec, e.cnt);
      check("err_sum", s_es, e.sum);
      check("max_err", s_me, e.maxe);
      check("max_a", s_ma, e.ma);
      check("max_b", s_mb, e.mb);
      repeat (3) @(posedge clk);
      #1;
      check("hold_sum", s_es, e.sum);
      check("hold_done", s_done, 1);
      check("hold_ab", {s_a, s_b}, N - 1);
    end
  endtask

  initial begin
    #2;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_ab", {a0, b0}, 0);
    check("rst_cnt", ec0, 0);
    check("rst_done2", done2, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_sweep(0, 0, -1, 1);               // exact loopback
    run_sweep(0, 1, -1, 1);               // tied to zero, from DONE
    check("zero_cnt_const", ec0, 225);
    check("zero_sum_const", es0, 14400);
    run_sweep(0, 2, -1, 1);               // bit0 dropped
    check("bit0_max_a", ma0, 1);
    check("bit0_max_b", mb0, 1);
    run_sweep(0, 3, 50, 1);               // mid-sweep start ignored

    one_reg = 1'b0;
    run_sweep(1, 0, -1, 1);               // aligned LAT=2
    one_reg = 1'b1;
    run_sweep(1, 0, -1, 0);               // misaligned LAT=2
    check("lat_misalign_err", ec2 != 0, 1);
    check("lat_misalign_cyc", last_cyc, N + 3);

    // Reset mid-sweep with nonzero accumulators.
    @(negedge clk);
    sel = 0;
    mode = 1;
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (100) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    check("abort_ab", {a0, b0}, 0);
    check("abort_cnt", ec0, 0);
    check("abort_sum", es0, 0);
    check("abort_max", {me0, ma0, mb0}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("abort_idle", busy0, 0);
    run_sweep(0, 0, -1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
